pre_if_stage: RTL and testbench

//  Pre-IF fetch stage, directly upstream of the IF stage. Generates the fetch PC and issues instruction

---
 rtl/pre_if_stage.sv | 139 +++++++++++++
 tb/tb_pre_if_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/pre_if_stage.sv
// Pre-IF fetch: PC generation, single-outstanding SRAM read, one-entry hold buffer; 2 cycles/inst minimum.
// Backpressure: fs_allowin=0 parks returned data in inst_buf (HOLD); branches squash in-flight/buffered work.
module pre_if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic [32:0] br_bus,
    output logic        pfs_to_fs_valid,
    output logic [63:0] pfs_to_fs_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] req_pc;
    logic [31:0] inst_buf;
    logic        cancel;

    logic        br_taken;
    logic [31:0] br_target;

    assign br_taken  = br_bus[32];
    assign br_target = br_bus[31:0];

    // A branch in the request cycle steers the address directly, so no bubble is spent on redirect.
    assign inst_sram_addr  = br_taken ? br_target : fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_REQ: begin
                if (inst_sram_addr_ok) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (inst_sram_data_ok) begin
                    if (cancel || br_taken || fs_allowin) begin
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (br_taken || fs_allowin) begin
                    state_nxt = S_REQ;
                end
            end
            default: state_nxt = S_REQ;
        endcase
    end

    always_comb begin
        inst_sram_req   = 1'b0;
        pfs_to_fs_valid = 1'b0;
        pfs_to_fs_bus   = 64'h0;
        if (!reset) begin
            inst_sram_req   = (state == S_REQ);
            pfs_to_fs_valid = (((state == S_WAIT) && inst_sram_data_ok && !cancel) ||
                               (state == S_HOLD)) && !br_taken;
            if (state == S_HOLD) begin
                pfs_to_fs_bus = {inst_buf, req_pc};
            end else begin
                pfs_to_fs_bus = {inst_sram_rdata, req_pc};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc <= RESET_PC;
            req_pc   <= 32'h0;
            inst_buf <= 32'h0;
            cancel   <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (inst_sram_addr_ok) begin
                        req_pc   <= inst_sram_addr;
                        fetch_pc <= inst_sram_addr + 32'd4;
                    end else if (br_taken) begin
                        fetch_pc <= br_target;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        cancel <= 1'b0;
                        if (br_taken) begin
                            fetch_pc <= br_target;
                        end else if (!cancel && !fs_allowin) begin
                            inst_buf <= inst_sram_rdata;
                        end
                    end else if (br_taken) begin
                        // The outstanding read is still owed to us; remember to discard it.
                        cancel   <= 1'b1;
                        fetch_pc <= br_target;
                    end
                end
                S_HOLD: begin
                    if (br_taken) begin
                        fetch_pc <= br_target;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_stage.sv
// Random SRAM latency / allowin / branch stimulus; scoreboard checks handed-over {inst,pc} against program order.
module tb_pre_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fs_allowin;
    logic [32:0] br_bus;
    logic        pfs_to_fs_valid;
    logic [63:0] pfs_to_fs_bus;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    pre_if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .br_bus            (br_bus),
        .pfs_to_fs_valid   (pfs_to_fs_valid),
        .pfs_to_fs_bus     (pfs_to_fs_bus),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          transfers = 0;
    logic [31:0] exp_q[$];
    logic        running = 1'b0;

    // SRAM model state, as it will be after the coming clock edge
    logic        outstanding = 1'b0;
    logic [31:0] out_addr = 32'h0;
    int          lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5a_1234;
    endfunction

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(3))
            0: t = 32'h1c000100;
            1: t = 32'h1c000200;
            2: t = 32'hfffffffc;
            default: t = {$urandom_range(32'h3fffffff), 2'b00};
        endcase
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every transfer must be the next instruction in program order.
    logic        prev_hold = 1'b0;
    logic [63:0] prev_bus = 64'h0;
    logic [31:0] e;
    always @(negedge clk) begin
        if (running && !reset) begin
            if (prev_hold && !br_bus[32]) begin
                check("valid_held", pfs_to_fs_valid, 1);
                check("bus_stable", pfs_to_fs_bus, prev_bus);
            end
            if (pfs_to_fs_valid && fs_allowin) begin
                transfers++;
                check("exp_depth", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("pc", pfs_to_fs_bus[31:0], e);
                    check("inst", pfs_to_fs_bus[63:32], mem_word(e));
                    exp_q.push_back(e + 32'd4);
                end
            end
            prev_hold = pfs_to_fs_valid && !fs_allowin;
            prev_bus  = pfs_to_fs_bus;
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic do_reset();
        running = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        br_bus = 33'h0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        fs_allowin = 1'b1;
        outstanding = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("rst_req", inst_sram_req, 0);
            check("rst_valid", pfs_to_fs_valid, 0);
            check("rst_bus", pfs_to_fs_bus, 0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q = {};
        exp_q.push_back(RESET_PC);
        running = 1'b1;
        #1;
        check("first_req", inst_sram_req, 1);
        check("first_addr", inst_sram_addr, RESET_PC);
        check("tie_wr", inst_sram_wr, 0);
        check("tie_size", inst_sram_size, 2'b10);
        check("tie_wstrb", inst_sram_wstrb, 0);
        check("tie_wdata", inst_sram_wdata, 0);
    endtask

    task automatic run_random(input int n, input int allow_pct, input int br_pct);
        logic [31:0] t;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            br_bus = 33'h0;
            if ($urandom_range(99) < br_pct) begin
                t = pick_target();
                br_bus = {1'b1, t};
                exp_q.delete();
                exp_q.push_back(t);
            end
            fs_allowin = ($urandom_range(99) < allow_pct);
            #1;
            check("one_outstanding", inst_sram_req && outstanding, 0);
            inst_sram_addr_ok = ($urandom_range(99) < 60);
            inst_sram_data_ok = outstanding && (lat == 0);
            inst_sram_rdata   = inst_sram_data_ok ? mem_word(out_addr) : $urandom;
            if (inst_sram_data_ok) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                lat--;
            end
            if (inst_sram_req && inst_sram_addr_ok) begin
                outstanding = 1'b1;
                out_addr    = inst_sram_addr;
                lat         = $urandom_range(3);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        fs_allowin = 1'b0;
        br_bus = 33'h0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        inst_sram_rdata = 32'h0;
        do_reset();
        run_random(1500, 90, 6);
        do_reset();
        run_random(1500, 40, 10);
        do_reset();
        run_random(600, 100, 0);
        running = 1'b0;
        check("progress", transfers > 300, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
